// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state encodings plus the NZP flag helper shared by the ALU files.
package alu_pkg;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_AND = 3'b001,
      OP_NOT = 3'b010,
      OP_PASS = 3'b011,
      OP_SUB = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } aluk_t;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   // Callers sign-extend their result to 64 bits, so bit 63 is the sign for any W up to 64.
   function automatic logic [2:0] nzp_of(input logic [63:0] r);
      return {r[63], r == 64'd0, !r[63] && r != 64'd0};
   endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ops; anything else passes A through.
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 16
) (
   input  aluk_t          op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [W-1:0]   y
);
   always_comb y = op == OP_ADD ? a + b :
                   op == OP_AND ? a & b :
                   op == OP_NOT ? ~a :
                   op == OP_SUB ? a - b : a;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative shifts and shift-add multiply, registered result and NZP.
module alu_seq
   import alu_pkg::*;
#(
   parameter int W = 16,
   parameter int SHW = $clog2(W)
) (
   input  logic           Clk,
   input  logic           Reset_ah,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2:0]     ALUK,
   input  logic [W-1:0]   SR1_out,
   input  logic [W-1:0]   SR2_out,
   input  logic [W-1:0]   SEXT_result,
   input  logic           SR2MUX,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   result,
   output logic [2:0]     nzp,
   output logic           busy
);
   state_t state;
   aluk_t op_in, op_r;
   logic [W-1:0] b_in, core_y, x, x_nx, mc, mp;
   logic [SHW-1:0] s_in;
   logic [SHW:0] cnt;
   logic go, multi;
   alu_core #(.W(W)) u_core (.op(op_in), .a(SR1_out), .b(b_in), .y(core_y));
   always_comb begin
      op_in = aluk_t'(ALUK);
      b_in = SR2MUX ? SEXT_result : SR2_out;
      s_in = b_in[SHW-1:0];
      multi = op_in == OP_MUL || ((op_in == OP_SHL || op_in == OP_SHR) && s_in != '0);
      in_ready = state == IDLE || (state == DONE && out_ready);
      out_valid = state == DONE;
      busy = state == CALC;
      go = in_valid && in_ready;
      // x is the multiply accumulator for MUL and the shifting operand for SHL/SHR
      x_nx = op_r == OP_MUL ? x + (mp[0] ? mc : '0) : op_r == OP_SHL ? x << 1 : x >> 1;
   end
   always_ff @(posedge Clk) begin
      if (Reset_ah) begin
         state <= IDLE;
         result <= '0;
         nzp <= 3'b000;
         op_r <= OP_ADD;
         x <= '0;
         mc <= '0;
         mp <= '0;
         cnt <= '0;
      end else if (go) begin
         op_r <= op_in;
         mc <= SR1_out;
         mp <= b_in;
         x <= op_in == OP_MUL ? '0 : SR1_out;
         cnt <= op_in == OP_MUL ? (SHW+1)'(W) : {1'b0, s_in};
         state <= multi ? CALC : DONE;
         if (!multi) begin
            result <= core_y;
            nzp <= nzp_of(64'(signed'(core_y)));
         end
      end else if (state == DONE && out_ready) begin
         state <= IDLE;
      end else if (state == CALC) begin
         x <= x_nx;
         mc <= mc << 1;
         mp <= mp >> 1;
         cnt <= cnt - 1'b1;
         if (cnt == 1) begin
            result <= x_nx;
            nzp <= nzp_of(64'(signed'(x_nx)));
            state <= DONE;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenario tasks with hand-computed expectations for alu_seq at W = 16.
module tb_alu_seq;
   logic Clk = 1'b0;
   logic Reset_ah, in_valid, out_ready, SR2MUX;
   logic [2:0] ALUK;
   logic [15:0] SR1_out, SR2_out, SEXT_result;
   logic in_ready, out_valid, busy;
   logic [15:0] result;
   logic [2:0] nzp;
   int total = 0, passed = 0;

   alu_seq #(.W(16)) dut (
      .Clk(Clk), .Reset_ah(Reset_ah), .in_valid(in_valid), .in_ready(in_ready), .ALUK(ALUK),
      .SR1_out(SR1_out), .SR2_out(SR2_out), .SEXT_result(SEXT_result), .SR2MUX(SR2MUX),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .nzp(nzp), .busy(busy)
   );

   always #5 Clk = ~Clk;

   task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic sel);
      in_valid = 1'b1; ALUK = op; SR1_out = a; SR2_out = b; SEXT_result = imm; SR2MUX = sel;
   endtask

   task automatic accept;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      SR1_out = 16'hDEAD; SR2_out = 16'hBEEF; SEXT_result = 16'h5A5A; ALUK = 3'b010;
   endtask

   task automatic wait_done(output int n, output int nb);
      n = 1; nb = 0;
      while (!out_valid && n < 40) begin
         nb += int'(busy);
         @(posedge Clk); #1;
         n++;
      end
   endtask

   task automatic test_reset;
      Reset_ah = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(3'b000, 16'h0, 16'h0, 16'h0, 1'b0); in_valid = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      total++; if (result !== 16'h0) $display("FAIL reset_result: got %h expected 0000", result); else passed++;
      total++; if (nzp !== 3'b000) $display("FAIL reset_nzp: got %b expected 000", nzp); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
      Reset_ah = 1'b0;
   endtask

   task automatic test_add;
      int n, nb;
      @(posedge Clk); #1;
      drive(3'b000, 16'h7FFF, 16'h1234, 16'h0001, 1'b1);
      accept();
      wait_done(n, nb);
      total++; if (n !== 1) $display("FAIL add_latency: got %0d expected 1", n); else passed++;
      total++; if (result !== 16'h8000) $display("FAIL add_result: got %h expected 8000", result); else passed++;
      total++; if (nzp !== 3'b100) $display("FAIL add_nzp: got %b expected 100", nzp); else passed++;
   endtask

   task automatic test_legacy;
      int n, nb;
      @(posedge Clk); #1;
      drive(3'b010, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
      accept(); wait_done(n, nb);
      total++; if (result !== 16'h0000) $display("FAIL not_result: got %h expected 0000", result); else passed++;
      total++; if (nzp !== 3'b010) $display("FAIL not_nzp: got %b expected 010", nzp); else passed++;
      @(posedge Clk); #1;
      drive(3'b001, 16'hF0F0, 16'h0FF0, 16'hFFFF, 1'b0);
      accept(); wait_done(n, nb);
      total++; if (result !== 16'h00F0) $display("FAIL and_result: got %h expected 00f0", result); else passed++;
      total++; if (nzp !== 3'b001) $display("FAIL and_nzp: got %b expected 001", nzp); else passed++;
      @(posedge Clk); #1;
      drive(3'b011, 16'h1234, 16'hFFFF, 16'hFFFF, 1'b1);
      accept(); wait_done(n, nb);
      total++; if (result !== 16'h1234) $display("FAIL pass_result: got %h expected 1234", result); else passed++;
   endtask

   task automatic test_back_to_back;
      logic [2:0] ops [4] = '{3'b000, 3'b100, 3'b010, 3'b011};
      logic [15:0] as [4] = '{16'h0001, 16'h0010, 16'h00FF, 16'h8000};
      logic [15:0] bs [4] = '{16'h0002, 16'h0003, 16'h0000, 16'h0000};
      logic [15:0] ex [4] = '{16'h0003, 16'h000D, 16'hFF00, 16'h8000};
      @(posedge Clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(ops[i], as[i], bs[i], 16'h0, 1'b0);
         @(posedge Clk); #1;
         total++; if (out_valid !== 1'b1 || result !== ex[i])
            $display("FAIL b2b_%0d: got valid %b result %h expected valid 1 result %h", i, out_valid, result, ex[i]);
         else passed++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_shift;
      int n, nb;
      @(posedge Clk); #1;
      drive(3'b101, 16'h0001, 16'hFFF4, 16'h0000, 1'b0);
      accept(); wait_done(n, nb);
      total++; if (n !== 5) $display("FAIL shl_latency: got %0d expected 5", n); else passed++;
      total++; if (nb !== 4) $display("FAIL shl_busy_cycles: got %0d expected 4", nb); else passed++;
      total++; if (result !== 16'h0010) $display("FAIL shl_result: got %h expected 0010", result); else passed++;
      @(posedge Clk); #1;
      drive(3'b110, 16'h8000, 16'h0000, 16'h000F, 1'b1);
      accept(); wait_done(n, nb);
      total++; if (n !== 16) $display("FAIL shr_latency: got %0d expected 16", n); else passed++;
      total++; if (result !== 16'h0001) $display("FAIL shr_result: got %h expected 0001", result); else passed++;
      @(posedge Clk); #1;
      drive(3'b101, 16'hABCD, 16'h0010, 16'h0000, 1'b0);
      accept(); wait_done(n, nb);
      total++; if (n !== 1) $display("FAIL shl0_latency: got %0d expected 1", n); else passed++;
      total++; if (result !== 16'hABCD) $display("FAIL shl0_result: got %h expected abcd", result); else passed++;
   endtask

   task automatic test_mul;
      int n = 1, bad = 0;
      @(posedge Clk); #1;
      drive(3'b111, 16'h0003, 16'hFFFE, 16'h0000, 1'b0);
      accept();
      while (!out_valid && n < 40) begin
         if (n == 3 || n == 4) drive(3'b000, 16'h1111, 16'h2222, 16'h0, 1'b0);
         else in_valid = 1'b0;
         if (in_ready !== 1'b0) bad++;
         @(posedge Clk); #1;
         n++;
      end
      in_valid = 1'b0;
      total++; if (bad !== 0) $display("FAIL mul_in_ready_calc: got %0d ready cycles expected 0", bad); else passed++;
      total++; if (n !== 17) $display("FAIL mul_latency: got %0d expected 17", n); else passed++;
      total++; if (result !== 16'hFFFA) $display("FAIL mul_result: got %h expected fffa", result); else passed++;
      total++; if (nzp !== 3'b100) $display("FAIL mul_nzp: got %b expected 100", nzp); else passed++;
   endtask

   task automatic test_backpressure;
      int n, nb, unstable = 0;
      @(posedge Clk); #1;
      out_ready = 1'b0;
      drive(3'b100, 16'h0005, 16'h0007, 16'h0000, 1'b0);
      accept(); wait_done(n, nb);
      total++; if (result !== 16'hFFFE) $display("FAIL sub_result: got %h expected fffe", result); else passed++;
      total++; if (nzp !== 3'b100) $display("FAIL sub_nzp: got %b expected 100", nzp); else passed++;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk); #1;
         if (out_valid !== 1'b1 || result !== 16'hFFFE || nzp !== 3'b100 || in_ready !== 1'b0) unstable++;
      end
      total++; if (unstable !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable); else passed++;
      out_ready = 1'b1; #1;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_follow: got %b expected 1", in_ready); else passed++;
      @(posedge Clk); #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_release: got valid %b ready %b expected valid 0 ready 1", out_valid, in_ready);
      else passed++;
   endtask

   task automatic test_reset_mid;
      int n, nb;
      @(posedge Clk); #1;
      drive(3'b111, 16'h0005, 16'h0007, 16'h0000, 1'b0);
      accept();
      repeat (7) @(posedge Clk);
      #1;
      total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else passed++;
      Reset_ah = 1'b1;
      @(posedge Clk); #1;
      Reset_ah = 1'b0;
      total++; if (result !== 16'h0 || nzp !== 3'b000 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL mid_reset: got result %h nzp %b valid %b busy %b ready %b expected 0000 000 0 0 1",
                  result, nzp, out_valid, busy, in_ready);
      else passed++;
      drive(3'b000, 16'h0002, 16'h0003, 16'h0000, 1'b0);
      accept(); wait_done(n, nb);
      total++; if (n !== 1) $display("FAIL post_reset_latency: got %0d expected 1", n); else passed++;
      total++; if (result !== 16'h0005) $display("FAIL post_reset_add: got %h expected 0005", result); else passed++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_legacy();
      test_back_to_back();
      test_shift();
      test_mul();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
